// File: rtl/dea_stream_ctrl.sv
// -----------------------------------------------------------------------------
// dea_stream_ctrl
//
// Stream controller for an external byte-wide XOR cipher datapath ("DEA").
// A 32-bit key is loaded into the datapath one byte per cycle, most
// significant byte first. Plaintext bytes are then streamed through it. The
// datapath returns each ciphertext byte one cycle after it is clocked in.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   key_start, key_word   single-cycle key-load request and the key to load
//   s_valid/s_data/s_last/s_ready   plaintext byte stream (sink side)
//   m_valid/m_data/m_last/m_ready   ciphertext byte stream (source side)
//   dea_kset, dea_dclk, dea_din     strobes and data into the XOR datapath
//   dea_dout              datapath result, valid one cycle after dea_dclk
//   key_ok                a complete key is resident in the datapath
//   busy                  key load, frame reception or frame flush under way
//   frame_len             bytes accepted in the current/last frame (saturating)
// -----------------------------------------------------------------------------
module dea_stream_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_start,
    input  logic [31:0] key_word,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic        m_valid,
    output logic [7:0]  m_data,
    output logic        m_last,
    input  logic        m_ready,
    output logic        dea_kset,
    output logic        dea_dclk,
    output logic [7:0]  dea_din,
    input  logic [7:0]  dea_dout,
    output logic        key_ok,
    output logic        busy,
    output logic [15:0] frame_len
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_KEY   = 3'd1;
    localparam logic [2:0] ST_READY = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_FLUSH = 3'd4;

    logic [2:0]  state_r;
    logic [31:0] key_r;
    logic [1:0]  key_cnt_r;
    logic        key_ok_r;
    logic        m_valid_r;
    logic        m_last_r;
    logic [15:0] frame_len_r;

    logic        reload_s;
    logic        s_ready_s;
    logic        accept_s;
    logic        kset_s;
    logic [7:0]  key_byte_s;
    logic [7:0]  din_s;

    // Input-side handshake: a key reload request in READY takes priority over
    // byte acceptance, so s_ready drops for that cycle to avoid losing a byte.
    always_comb begin
        reload_s  = 1'b0;
        s_ready_s = 1'b0;
        if ((state_r == ST_READY) && key_start) begin
            reload_s = 1'b1;
        end else begin
            reload_s = 1'b0;
        end
        if (reset) begin
            s_ready_s = 1'b0;
        end else if (((state_r == ST_READY) || (state_r == ST_RUN)) && !reload_s) begin
            // Room exists when the output slot is empty or drains this cycle.
            s_ready_s = !m_valid_r || m_ready;
        end else begin
            s_ready_s = 1'b0;
        end
        accept_s = s_valid && s_ready_s;
    end

    // Datapath drive: key bytes during KEY, plaintext on accept, else zero.
    // Strobes are gated by reset so an aborting cycle issues no pulse.
    always_comb begin
        kset_s     = (!reset) && (state_r == ST_KEY);
        key_byte_s = 8'h00;
        din_s      = 8'h00;
        case (key_cnt_r)
            2'd0:    key_byte_s = key_r[31:24];
            2'd1:    key_byte_s = key_r[23:16];
            2'd2:    key_byte_s = key_r[15:8];
            2'd3:    key_byte_s = key_r[7:0];
            default: key_byte_s = 8'h00;
        endcase
        if (kset_s) begin
            din_s = key_byte_s;
        end else if (accept_s) begin
            din_s = s_data;
        end else begin
            din_s = 8'h00;
        end
    end

    // Control FSM, key capture/sequencing and frame length counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            key_r       <= 32'h0000_0000;
            key_cnt_r   <= 2'd0;
            key_ok_r    <= 1'b0;
            frame_len_r <= 16'h0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (key_start) begin
                        key_r     <= key_word;
                        key_cnt_r <= 2'd0;
                        state_r   <= ST_KEY;
                    end
                end
                ST_KEY: begin
                    key_cnt_r <= key_cnt_r + 2'd1;
                    if (key_cnt_r == 2'd3) begin
                        key_ok_r <= 1'b1;
                        state_r  <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (reload_s) begin
                        key_r     <= key_word;
                        key_cnt_r <= 2'd0;
                        key_ok_r  <= 1'b0;
                        state_r   <= ST_KEY;
                    end else if (accept_s) begin
                        frame_len_r <= 16'd1;
                        state_r     <= s_last ? ST_FLUSH : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept_s) begin
                        if (frame_len_r != 16'hFFFF) begin
                            frame_len_r <= frame_len_r + 16'd1;
                        end
                        if (s_last) begin
                            state_r <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Only the last byte can be pending here.
                    if (m_valid_r && m_ready) begin
                        state_r <= ST_READY;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    key_ok_r <= 1'b0;
                end
            endcase
        end
    end

    // Output slot: filled on accept, drained on m_ready, held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
        end else if (accept_s) begin
            m_valid_r <= 1'b1;
            m_last_r  <= s_last;
        end else if (m_ready) begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
        end
    end

    // The datapath registers its result on the accept edge and holds it until
    // the next dclk, which cannot occur while the slot is stalled, so its
    // output is presented directly to keep the one-cycle latency.
    assign m_data    = m_valid_r ? dea_dout : 8'h00;
    assign m_valid   = m_valid_r;
    assign m_last    = m_last_r;
    assign s_ready   = s_ready_s;
    assign dea_kset  = kset_s;
    assign dea_dclk  = accept_s;
    assign dea_din   = din_s;
    assign key_ok    = key_ok_r;
    assign busy      = (state_r == ST_KEY) || (state_r == ST_RUN) || (state_r == ST_FLUSH);
    assign frame_len = frame_len_r;

endmodule

// File: tb/tb_dea_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dea_stream_ctrl
//
// Bench for dea_stream_ctrl. It contains a behavioural model of the external
// XOR datapath, directed scenarios, a randomized run checked against a
// transaction-level model, and a frame-length saturation run.
// -----------------------------------------------------------------------------
module tb_dea_stream_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_start;
    logic [31:0] key_word;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_ready;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_ready;
    logic        dea_kset;
    logic        dea_dclk;
    logic [7:0]  dea_din;
    logic [7:0]  dea_dout;
    logic        key_ok;
    logic        busy;
    logic [15:0] frame_len;

    int checks = 0;
    int errors = 0;
    int viol   = 0;

    always #5 clk = ~clk;

    dea_stream_ctrl dut (
        .clk(clk), .reset(reset), .key_start(key_start), .key_word(key_word),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .dea_kset(dea_kset), .dea_dclk(dea_dclk), .dea_din(dea_din), .dea_dout(dea_dout),
        .key_ok(key_ok), .busy(busy), .frame_len(frame_len)
    );

    // Behavioural XOR datapath: strobes are sampled mid-cycle and applied on
    // the following rising edge.
    logic [31:0] dp_key  = 32'h0;
    logic [7:0]  dp_dout = 8'h00;
    logic        smp_kset = 1'b0;
    logic        smp_dclk = 1'b0;
    logic [7:0]  smp_din  = 8'h00;
    assign dea_dout = dp_dout;

    always @(negedge clk) begin
        smp_kset = dea_kset;
        smp_dclk = dea_dclk;
        smp_din  = dea_din;
        if (dea_kset && dea_dclk) viol++;
        if (!dea_kset && !dea_dclk && (dea_din != 8'h00)) viol++;
    end

    always @(posedge clk) begin
        if (smp_kset) dp_key <= {dp_key[23:0], smp_din};
        if (smp_dclk) dp_dout <= smp_din ^ dp_key[7:0];
    end

    initial begin
        #900000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        key_start = 1'b0; key_word = 32'h0; s_valid = 1'b0;
        s_data = 8'h00; s_last = 1'b0; m_ready = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++; if (key_ok !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_status got key_ok=%0b busy=%0b exp 0 0", key_ok, busy); end
        checks++; if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0) begin errors++; $display("FAIL reset_stream got s_ready=%0b m_valid=%0b m_last=%0b exp 0 0 0", s_ready, m_valid, m_last); end
        checks++; if (m_data !== 8'h00 || frame_len !== 16'h0000) begin errors++; $display("FAIL reset_data got m_data=%0h frame_len=%0h exp 0 0", m_data, frame_len); end
        checks++; if (dea_kset !== 1'b0 || dea_dclk !== 1'b0 || dea_din !== 8'h00) begin errors++; $display("FAIL reset_dea got kset=%0b dclk=%0b din=%0h exp 0 0 0", dea_kset, dea_dclk, dea_din); end
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_no_key();
        s_valid = 1'b1; s_data = 8'h5A; m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (s_ready !== 1'b0 || dea_dclk !== 1'b0) begin errors++; $display("FAIL nokey_accept cyc %0d got s_ready=%0b dclk=%0b exp 0 0", i, s_ready, dea_dclk); end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_key_load(input logic [31:0] kw);
        logic [7:0] exp_b;
        key_start = 1'b1; key_word = kw;
        next_cycle();
        key_start = 1'b0; key_word = 32'h0;
        for (int i = 0; i < 4; i++) begin
            exp_b = kw[31 - 8*i -: 8];
            @(negedge clk);
            checks++; if (dea_kset !== 1'b1 || dea_din !== exp_b) begin errors++; $display("FAIL key_byte %0d got kset=%0b din=%0h exp 1 %0h", i, dea_kset, dea_din, exp_b); end
            checks++; if (key_ok !== 1'b0 || busy !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("FAIL key_status %0d got key_ok=%0b busy=%0b s_ready=%0b exp 0 1 0", i, key_ok, busy, s_ready); end
            next_cycle();
        end
        @(negedge clk);
        checks++; if (key_ok !== 1'b1 || dea_kset !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL key_done got key_ok=%0b kset=%0b busy=%0b exp 1 0 0", key_ok, dea_kset, busy); end
        next_cycle();
    endtask

    // Key low byte EF, frame 00,FF,10 -> ciphertext EF,10,FF.
    task automatic test_frame();
        logic [7:0] pt [3];
        logic [7:0] ct [3];
        pt[0] = 8'h00; pt[1] = 8'hFF; pt[2] = 8'h10;
        ct[0] = 8'hEF; ct[1] = 8'h10; ct[2] = 8'hFF;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_valid = (i < 3);
            s_data  = (i < 3) ? pt[i] : 8'h00;
            s_last  = (i == 2);
            @(negedge clk);
            if (i < 3) begin
                checks++; if (s_ready !== 1'b1 || dea_dclk !== 1'b1 || dea_din !== pt[i]) begin errors++; $display("FAIL frame_accept %0d got s_ready=%0b dclk=%0b din=%0h exp 1 1 %0h", i, s_ready, dea_dclk, dea_din, pt[i]); end
            end
            if (i > 0) begin
                checks++; if (m_valid !== 1'b1 || m_data !== ct[i-1] || m_last !== (i == 3)) begin errors++; $display("FAIL frame_out %0d got v=%0b d=%0h l=%0b exp 1 %0h %0b", i-1, m_valid, m_data, m_last, ct[i-1], (i == 3)); end
            end
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        checks++; if (frame_len !== 16'd3 || busy !== 1'b0 || m_valid !== 1'b0 || key_ok !== 1'b1) begin errors++; $display("FAIL frame_end got len=%0d busy=%0b m_valid=%0b key_ok=%0b exp 3 0 0 1", frame_len, busy, m_valid, key_ok); end
        next_cycle();
    endtask

    task automatic test_backpressure();
        logic [7:0] c0;
        logic [7:0] c1;
        c0 = 8'hA1 ^ 8'hEF;
        c1 = 8'hB2 ^ 8'hEF;
        s_valid = 1'b1; s_data = 8'hA1; s_last = 1'b0; m_ready = 1'b1;
        next_cycle();
        s_data = 8'hB2; s_last = 1'b1; m_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (s_ready !== 1'b0 || dea_dclk !== 1'b0) begin errors++; $display("FAIL bp_stall %0d got s_ready=%0b dclk=%0b exp 0 0", i, s_ready, dea_dclk); end
            checks++; if (m_valid !== 1'b1 || m_data !== c0 || m_last !== 1'b0) begin errors++; $display("FAIL bp_hold %0d got v=%0b d=%0h l=%0b exp 1 %0h 0", i, m_valid, m_data, m_last, c0); end
            next_cycle();
        end
        m_ready = 1'b1;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1 || dea_dclk !== 1'b1 || m_data !== c0) begin errors++; $display("FAIL bp_resume got s_ready=%0b dclk=%0b d=%0h exp 1 1 %0h", s_ready, dea_dclk, m_data, c0); end
        next_cycle();
        s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        checks++; if (m_valid !== 1'b1 || m_data !== c1 || m_last !== 1'b1) begin errors++; $display("FAIL bp_second got v=%0b d=%0h l=%0b exp 1 %0h 1", m_valid, m_data, m_last, c1); end
        next_cycle();
        @(negedge clk);
        checks++; if (m_valid !== 1'b0 || frame_len !== 16'd2) begin errors++; $display("FAIL bp_end got v=%0b len=%0d exp 0 2", m_valid, frame_len); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_key_in_run();
        m_ready = 1'b1; s_valid = 1'b1; s_data = 8'h11; s_last = 1'b0;
        next_cycle();
        key_start = 1'b1; key_word = 32'h1234_5678; s_data = 8'h22; s_last = 1'b1;
        @(negedge clk);
        checks++; if (dea_kset !== 1'b0 || dea_dclk !== 1'b1 || key_ok !== 1'b1) begin errors++; $display("FAIL run_key_ignored got kset=%0b dclk=%0b key_ok=%0b exp 0 1 1", dea_kset, dea_dclk, key_ok); end
        next_cycle();
        key_start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        checks++; if (dea_kset !== 1'b0 || m_data !== (8'h22 ^ 8'hEF) || m_last !== 1'b1) begin errors++; $display("FAIL run_key_data got kset=%0b d=%0h l=%0b exp 0 %0h 1", dea_kset, m_data, m_last, 8'h22 ^ 8'hEF); end
        next_cycle();
        test_key_load(32'h0000_0055);
        s_valid = 1'b1; s_data = 8'h55; s_last = 1'b1; m_ready = 1'b1;
        next_cycle();
        s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h00) begin errors++; $display("FAIL reload_55 got v=%0b d=%0h exp 1 00", m_valid, m_data); end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b1; s_valid = 1'b1; s_data = 8'h01; s_last = 1'b0;
        next_cycle();
        s_data = 8'h02;
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (dea_dclk !== 1'b0 || dea_kset !== 1'b0) begin errors++; $display("FAIL rstmid_pulse got dclk=%0b kset=%0b exp 0 0", dea_dclk, dea_kset); end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 8'h00 || frame_len !== 16'h0) begin errors++; $display("FAIL rstmid_stream got v=%0b l=%0b d=%0h len=%0h exp 0 0 0 0", m_valid, m_last, m_data, frame_len); end
        checks++; if (key_ok !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0 || dea_dclk !== 1'b0 || dea_din !== 8'h00) begin errors++; $display("FAIL rstmid_ctrl got key_ok=%0b busy=%0b s_ready=%0b dclk=%0b din=%0h exp 0 0 0 0 0", key_ok, busy, s_ready, dea_dclk, dea_din); end
        next_cycle();
        @(negedge clk);
        checks++; if (s_ready !== 1'b0 || dea_dclk !== 1'b0) begin errors++; $display("FAIL rstmid_nokey got s_ready=%0b dclk=%0b exp 0 0", s_ready, dea_dclk); end
        next_cycle();
        clear_inputs();
        key_start = 1'b1; key_word = 32'hCAFE_F00D;
        next_cycle();
        key_start = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (dea_kset !== 1'b0 || key_ok !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstkey_abort %0d got kset=%0b key_ok=%0b busy=%0b exp 0 0 0", i, dea_kset, key_ok, busy); end
            next_cycle();
        end
    endtask

    // Randomized traffic against a transaction-level model: a key register,
    // a queue of pending key bytes, a queue of ciphertext bytes owed to the
    // sink, and frame bookkeeping.
    task automatic test_random();
        logic [7:0]  key_q [$];
        logic [8:0]  out_q [$];
        logic [8:0]  popped;
        logic [7:0]  key_byte;
        logic [7:0]  new_key;
        logic [7:0]  exp_din;
        logic        keyed, in_frame, flushing, eff_key, exp_rdy, exp_acc, exp_busy;
        logic [15:0] flen;
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        keyed = 1'b0; in_frame = 1'b0; flushing = 1'b0; flen = 16'h0;
        key_byte = 8'h00; new_key = 8'h00;
        for (int n = 0; n < 2000; n++) begin
            m_ready   = ($urandom_range(0, 3) != 0);
            s_valid   = ($urandom_range(0, 2) != 0);
            s_data    = 8'($urandom);
            s_last    = ($urandom_range(0, 4) == 0);
            key_start = ($urandom_range(0, 24) == 0);
            key_word  = $urandom;
            eff_key  = key_start && (key_q.size() == 0) && (!keyed || (!in_frame && !flushing));
            exp_rdy  = keyed && !flushing && !eff_key && ((out_q.size() == 0) || m_ready);
            exp_acc  = s_valid && exp_rdy;
            exp_busy = (key_q.size() != 0) || in_frame || flushing;
            if (key_q.size() != 0) exp_din = key_q[0];
            else if (exp_acc)      exp_din = s_data;
            else                   exp_din = 8'h00;
            @(negedge clk);
            checks++; if (s_ready !== exp_rdy || dea_dclk !== exp_acc) begin errors++; $display("FAIL rnd_in %0d got s_ready=%0b dclk=%0b exp %0b %0b", n, s_ready, dea_dclk, exp_rdy, exp_acc); end
            checks++; if (dea_kset !== (key_q.size() != 0) || dea_din !== exp_din) begin errors++; $display("FAIL rnd_dea %0d got kset=%0b din=%0h exp %0b %0h", n, dea_kset, dea_din, (key_q.size() != 0), exp_din); end
            checks++; if (m_valid !== (out_q.size() != 0)) begin errors++; $display("FAIL rnd_mvalid %0d got %0b exp %0b", n, m_valid, (out_q.size() != 0)); end
            if (out_q.size() != 0) begin
                checks++; if ({m_last, m_data} !== out_q[0]) begin errors++; $display("FAIL rnd_mdata %0d got l=%0b d=%0h exp l=%0b d=%0h", n, m_last, m_data, out_q[0][8], out_q[0][7:0]); end
            end
            checks++; if (key_ok !== keyed || busy !== exp_busy || frame_len !== flen) begin errors++; $display("FAIL rnd_status %0d got key_ok=%0b busy=%0b len=%0d exp %0b %0b %0d", n, key_ok, busy, frame_len, keyed, exp_busy, flen); end
            if ((out_q.size() != 0) && m_ready) begin
                popped = out_q.pop_front();
                if (popped[8]) flushing = 1'b0;
            end
            if (key_q.size() != 0) begin
                void'(key_q.pop_front());
                if (key_q.size() == 0) begin
                    keyed = 1'b1;
                    key_byte = new_key;
                end
            end
            if (eff_key) begin
                key_q.push_back(key_word[31:24]);
                key_q.push_back(key_word[23:16]);
                key_q.push_back(key_word[15:8]);
                key_q.push_back(key_word[7:0]);
                keyed = 1'b0;
                new_key = key_word[7:0];
            end
            if (exp_acc) begin
                out_q.push_back({s_last, s_data ^ key_byte});
                if (!in_frame) flen = 16'd1;
                else if (flen != 16'hFFFF) flen = flen + 16'd1;
                if (s_last) begin
                    flushing = 1'b1;
                    in_frame = 1'b0;
                end else begin
                    in_frame = 1'b1;
                end
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_saturation();
        int nbytes;
        logic [15:0] exp_len;
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        key_start = 1'b1; key_word = 32'h0102_0304;
        next_cycle();
        key_start = 1'b0;
        for (int i = 0; i < 5; i++) next_cycle();
        nbytes = 65540;
        exp_len = (nbytes > 65535) ? 16'hFFFF : 16'(nbytes);
        s_valid = 1'b1; s_last = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
            s_data = 8'(i);
            next_cycle();
        end
        s_valid = 1'b0;
        @(negedge clk);
        checks++; if (frame_len !== exp_len || busy !== 1'b1) begin errors++; $display("FAIL sat_len got len=%0h busy=%0b exp %0h 1", frame_len, busy, exp_len); end
        next_cycle();
        s_valid = 1'b1; s_last = 1'b1; s_data = 8'h04;
        next_cycle();
        s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        checks++; if (frame_len !== 16'hFFFF || m_data !== 8'h00 || m_last !== 1'b1) begin errors++; $display("FAIL sat_last got len=%0h d=%0h l=%0b exp ffff 00 1", frame_len, m_data, m_last); end
        next_cycle();
        @(negedge clk);
        checks++; if (busy !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL sat_done got busy=%0b v=%0b exp 0 0", busy, m_valid); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_protocol();
        @(negedge clk);
        checks++; if (viol !== 0) begin errors++; $display("FAIL dea_protocol got %0d violations exp 0", viol); end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        #1;
        test_reset();
        test_no_key();
        test_key_load(32'hDEAD_BEEF);
        test_frame();
        test_backpressure();
        test_key_in_run();
        test_reset_mid();
        test_random();
        test_saturation();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dea_stream_ctrl.md
DEA_STREAM_CTRL -- requirements
Module: dea_stream_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-002 SHALL have key_start in 1, single-cycle key-load request; key_word in 32, key captured on key_start.
REQ-003 SHALL have s_valid in 1, s_data in 8, s_last in 1, s_ready out 1, plaintext byte stream.
REQ-004 SHALL have m_valid out 1, m_data out 8, m_last out 1, m_ready in 1, ciphertext byte stream.
REQ-005 SHALL have dea_kset out 1, dea_dclk out 1, dea_din out 8 driving the XOR datapath; dea_dout in 8 from it.
REQ-006 SHALL have key_ok out 1 (key loaded), busy out 1 (key load or frame in progress), frame_len out 16 (bytes accepted in current/last frame).
REQ-007 Datapath model: kset shifts din into key low byte; dclk registers din^key[7:0] into dout one cycle later; kset and dclk never asserted together.

Function
REQ-008 SHALL implement states IDLE, KEY, READY, RUN, FLUSH.
REQ-009 IDLE: key_ok=0; s_ready=0; key_start -> capture key_word, clear 2-bit key counter, go KEY.
REQ-010 KEY: dea_kset=1 for exactly 4 consecutive cycles, dea_din = key_word[31:24], [23:16], [15:8], [7:0] in that order; after 4th cycle go READY, key_ok=1.
REQ-011 KEY: s_ready=0, dea_dclk=0; key_start ignored.
REQ-012 READY: key_start -> reload (go KEY, key_ok=0 until complete); else byte acceptance per REQ-013, first accepted byte clears frame_len to 1 and enters RUN (or FLUSH if s_last).
REQ-013 s_ready = (state READY or RUN) and (m_valid=0 or m_ready=1); byte accepted when s_valid and s_ready.
REQ-014 On accept: dea_dclk=1, dea_din=s_data same cycle; next cycle m_valid=1, m_data=dea_dout, m_last=registered s_last.
REQ-015 Latency s_data accept -> m_valid exactly 1 cycle; throughput 1 byte/cycle when m_ready held high.
REQ-016 m_valid=1 and m_ready=0: m_valid, m_data, m_last held stable; no dclk issued.
REQ-017 m_valid cleared when m_ready=1 and no byte accepted same cycle; simultaneous consume+accept keeps m_valid=1 with new data.
REQ-018 RUN: key_start ignored; each accept increments frame_len, saturating at 16'hFFFF.
REQ-019 Accepting byte with s_last=1 -> FLUSH; FLUSH: s_ready=0, wait for m_valid&m_ready on last byte, then READY.
REQ-020 busy=1 in KEY, RUN, FLUSH; 0 in IDLE, READY.
REQ-021 dea_din=0 whenever neither kset nor dclk asserted.

Reset
REQ-022 reset SHALL force IDLE, key_ok=0, busy=0, s_ready=0, m_valid=0, m_last=0, m_data=0, frame_len=0, dea_kset=0, dea_dclk=0, dea_din=0.
REQ-023 reset mid-KEY or mid-RUN SHALL abort without further kset/dclk pulses; key must be reloaded before data is accepted.

Verification
REQ-024 key_start with key_word=32'hDEADBEEF -> kset 4 cycles, din DE,AD,BE,EF; key_ok=1 on 5th cycle.
REQ-025 Key ..EF, frame 8'h00,8'hFF,8'h10 (last on 3rd), m_ready=1 -> m_data EF,10,FF one cycle after each accept, m_last on 3rd, frame_len=3, state READY.
REQ-026 m_ready=0 two cycles with m_valid=1 -> s_ready=0, m_data stable, no dclk; m_ready=1 resumes without loss or duplication.
REQ-027 key_start during RUN -> ignored, key_ok stays 1, no kset; key_start in READY with 32'h00000055 -> next byte 8'h55 yields 8'h00.
REQ-028 s_valid before any key load -> s_ready=0, no dclk; reset asserted mid-frame -> all outputs per REQ-022 next cycle.
